// File: rtl/mma_timing_model.sv
// Cycle-approximate timing stand-in for the systolic MMA engine: queues jobs, checks their config, and models latency.
// Optional build macro MMA_MODEL_ICB_PROBE_EN adds a single ICB read probe of lhs_base before each good job runs.
module mma_timing_model #(
    parameter int SIZE       = 16,
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int LEN_WIDTH  = 3,
    parameter int QDEPTH     = 4,
    parameter int DIM_W      = 12,
    parameter int CNT_W      = 24,
    parameter int BASE_LAT   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   calc_start,
    input  logic                   cfg_16bits_ia,
    output logic                   sa_ready,
    output logic                   busy,
    input  logic [REG_WIDTH-1:0]   lhs_base,
    input  logic [REG_WIDTH-1:0]   rhs_base,
    input  logic [REG_WIDTH-1:0]   dst_base,
    input  logic [REG_WIDTH-1:0]   m,
    input  logic [REG_WIDTH-1:0]   n,
    input  logic [REG_WIDTH-1:0]   k,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [1:0]             err_code,
    output logic                   sa_icb_cmd_valid,
    output logic [ADDR_WIDTH-1:0]  sa_icb_cmd_addr,
    output logic                   sa_icb_cmd_read,
    output logic [LEN_WIDTH-1:0]   sa_icb_cmd_len,
    output logic [BUS_WIDTH-1:0]   sa_icb_cmd_wdata,
    output logic [BUS_WIDTH/8-1:0] sa_icb_cmd_wmask,
    output logic                   sa_icb_w_valid,
    output logic                   sa_icb_rsp_ready,
    input  logic                   sa_icb_cmd_ready,
    input  logic                   sa_icb_w_ready,
    input  logic                   sa_icb_rsp_valid,
    input  logic [BUS_WIDTH-1:0]   sa_icb_rsp_rdata,
    input  logic                   sa_icb_rsp_err
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);
    localparam int MW = 3 * (DIM_W + 1) + 1;
    localparam logic [DIM_W:0] SZ_C   = (DIM_W + 1)'(SIZE);
    localparam logic [DIM_W:0] SZM1_C = (DIM_W + 1)'(SIZE - 1);
    localparam logic [MW:0]    SAT_C  = {{(MW + 1 - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3
`ifdef MMA_MODEL_ICB_PROBE_EN
        , ST_PROBE = 3'd4
`endif
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_next_s;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic              sa_ready_r;
    logic              busy_r;
    logic              busy_next_s;
    logic              wb_valid_r;
    logic [1:0]        err_code_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              enq_s;
    logic              pop_s;
    logic [1:0]        err_s;

    logic [DIM_W-1:0]  q_m_r   [QDEPTH];
    logic [DIM_W-1:0]  q_n_r   [QDEPTH];
    logic [DIM_W-1:0]  q_k_r   [QDEPTH];
    logic              q_cfg_r [QDEPTH];
    logic [1:0]        q_err_r [QDEPTH];

    logic [DIM_W-1:0]  cur_m_r;
    logic [DIM_W-1:0]  cur_n_r;
    logic [DIM_W-1:0]  cur_k_r;
    logic              cur_cfg_r;
    logic [1:0]        cur_err_r;

    logic [DIM_W:0]    tm_s;
    logic [DIM_W:0]    tn_s;
    logic [MW-1:0]     prod_s;
    logic [MW-1:0]     prod2_s;
    logic [MW:0]       sum_s;
    logic [CNT_W-1:0]  lat_s;

`ifdef MMA_MODEL_ICB_PROBE_EN
    logic [ADDR_WIDTH-1:0] q_lhs_r [QDEPTH];
    logic [ADDR_WIDTH-1:0] cur_lhs_r;
    logic                  cmd_valid_r;
    logic                  cmd_read_r;
    logic [ADDR_WIDTH-1:0] cmd_addr_r;
`endif

    logic unused_s;
    assign unused_s = ^{sa_icb_cmd_ready, sa_icb_w_ready, sa_icb_rsp_valid, sa_icb_rsp_rdata,
                        sa_icb_rsp_err, lhs_base, rhs_base, dst_base};

    assign enq_s = calc_start && sa_ready_r;
    assign pop_s = (state_r == ST_IDLE) && (count_r != CW'(0));

    // Config check at enqueue: bad dimensions take priority over misaligned bases
    always_comb begin
        err_s = 2'b00;
        if (~|m[DIM_W-1:0] || |m[REG_WIDTH-1:DIM_W] ||
            ~|n[DIM_W-1:0] || |n[REG_WIDTH-1:DIM_W] ||
            ~|k[DIM_W-1:0] || |k[REG_WIDTH-1:DIM_W]) begin
            err_s = 2'b01;
        end else if (|lhs_base[1:0] || |rhs_base[1:0] || |dst_base[1:0]) begin
            err_s = 2'b10;
        end else begin
            err_s = 2'b00;
        end
    end

    // Next occupancy of the pending-job queue
    always_comb begin
        count_next_s = count_r;
        case ({enq_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Engine is idle next cycle only with an empty queue and the FSM settling in IDLE
    always_comb begin
        busy_next_s = 1'b1;
        if (count_next_s != CW'(0)) begin
            busy_next_s = 1'b1;
        end else if (state_r == ST_IDLE && !pop_s) begin
            busy_next_s = 1'b0;
        end else if (state_r == ST_DONE && wb_ready) begin
            busy_next_s = 1'b0;
        end else begin
            busy_next_s = 1'b1;
        end
    end

    // Latency model: tile count times k, doubled for 16-bit activations, plus fixed overhead, saturated
    always_comb begin
        tm_s    = ({1'b0, cur_m_r} + SZM1_C) / SZ_C;
        tn_s    = ({1'b0, cur_n_r} + SZM1_C) / SZ_C;
        prod_s  = MW'(tm_s) * MW'(tn_s) * MW'(cur_k_r);
        prod2_s = cur_cfg_r ? {prod_s[MW-2:0], 1'b0} : prod_s;
        sum_s   = {1'b0, prod2_s} + (MW + 1)'(BASE_LAT);
        lat_s   = {CNT_W{1'b1}};
        if (cur_err_r != 2'b00) begin
            lat_s = CNT_W'(1);
        end else if (sum_s > SAT_C) begin
            lat_s = {CNT_W{1'b1}};
        end else begin
            lat_s = sum_s[CNT_W-1:0];
        end
    end

    // Queue payload storage
    always_ff @(posedge clk) begin
        if (enq_s) begin
            q_m_r[wr_ptr_r]   <= m[DIM_W-1:0];
            q_n_r[wr_ptr_r]   <= n[DIM_W-1:0];
            q_k_r[wr_ptr_r]   <= k[DIM_W-1:0];
            q_cfg_r[wr_ptr_r] <= cfg_16bits_ia;
            q_err_r[wr_ptr_r] <= err_s;
`ifdef MMA_MODEL_ICB_PROBE_EN
            q_lhs_r[wr_ptr_r] <= ADDR_WIDTH'(lhs_base);
`endif
        end
    end

    // Queue pointers, occupancy and the registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            sa_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r    <= count_next_s;
            sa_ready_r <= (count_next_s != CW'(QDEPTH));
            busy_r     <= busy_next_s;
        end
    end

    // Job engine FSM with registered write-back outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            wb_valid_r <= 1'b0;
            err_code_r <= 2'b00;
            cur_m_r    <= {DIM_W{1'b0}};
            cur_n_r    <= {DIM_W{1'b0}};
            cur_k_r    <= {DIM_W{1'b0}};
            cur_cfg_r  <= 1'b0;
            cur_err_r  <= 2'b00;
`ifdef MMA_MODEL_ICB_PROBE_EN
            cur_lhs_r   <= {ADDR_WIDTH{1'b0}};
            cmd_valid_r <= 1'b0;
            cmd_read_r  <= 1'b0;
            cmd_addr_r  <= {ADDR_WIDTH{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        cur_m_r   <= q_m_r[rd_ptr_r];
                        cur_n_r   <= q_n_r[rd_ptr_r];
                        cur_k_r   <= q_k_r[rd_ptr_r];
                        cur_cfg_r <= q_cfg_r[rd_ptr_r];
                        cur_err_r <= q_err_r[rd_ptr_r];
`ifdef MMA_MODEL_ICB_PROBE_EN
                        cur_lhs_r <= q_lhs_r[rd_ptr_r];
`endif
                        state_r   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    cnt_r <= lat_s - CNT_W'(1);
`ifdef MMA_MODEL_ICB_PROBE_EN
                    if (cur_err_r == 2'b00) begin
                        cmd_valid_r <= 1'b1;
                        cmd_read_r  <= 1'b1;
                        cmd_addr_r  <= cur_lhs_r;
                        state_r     <= ST_PROBE;
                    end else begin
                        state_r <= ST_RUN;
                    end
`else
                    state_r <= ST_RUN;
`endif
                end
`ifdef MMA_MODEL_ICB_PROBE_EN
                ST_PROBE: begin
                    // Command phase first; the response is only taken once the command has gone
                    if (cmd_valid_r) begin
                        if (sa_icb_cmd_ready) begin
                            cmd_valid_r <= 1'b0;
                            cmd_read_r  <= 1'b0;
                            cmd_addr_r  <= {ADDR_WIDTH{1'b0}};
                        end
                    end else if (sa_icb_rsp_valid) begin
                        if (sa_icb_rsp_err) begin
                            cur_err_r  <= 2'b11;
                            err_code_r <= 2'b11;
                            wb_valid_r <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
`endif
                ST_RUN: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        wb_valid_r <= 1'b1;
                        err_code_r <= cur_err_r;
                        state_r    <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (wb_ready) begin
                        wb_valid_r <= 1'b0;
                        err_code_r <= 2'b00;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign sa_ready = sa_ready_r;
    assign busy     = busy_r;
    assign wb_valid = wb_valid_r;
    assign err_code = err_code_r;

`ifdef MMA_MODEL_ICB_PROBE_EN
    assign sa_icb_cmd_valid = cmd_valid_r;
    assign sa_icb_cmd_addr  = cmd_addr_r;
    assign sa_icb_cmd_read  = cmd_read_r;
`else
    assign sa_icb_cmd_valid = 1'b0;
    assign sa_icb_cmd_addr  = {ADDR_WIDTH{1'b0}};
    assign sa_icb_cmd_read  = 1'b0;
`endif
    assign sa_icb_cmd_len   = {LEN_WIDTH{1'b0}};
    assign sa_icb_cmd_wdata = {BUS_WIDTH{1'b0}};
    assign sa_icb_cmd_wmask = {(BUS_WIDTH/8){1'b0}};
    assign sa_icb_w_valid   = 1'b0;
    assign sa_icb_rsp_ready = 1'b1;

endmodule

// File: tb/tb_mma_timing_model.sv
// Directed self-checking bench for mma_timing_model (SIZE=16, BASE_LAT=4, QDEPTH=4).
module tb_mma_timing_model;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        calc_start, cfg_16bits_ia, sa_ready, busy;
    logic [31:0] lhs_base, rhs_base, dst_base, m, n, k;
    logic        wb_valid, wb_ready;
    logic [1:0]  err_code;
    logic        sa_icb_cmd_valid, sa_icb_cmd_read, sa_icb_w_valid, sa_icb_rsp_ready;
    logic [31:0] sa_icb_cmd_addr, sa_icb_cmd_wdata, sa_icb_rsp_rdata;
    logic [2:0]  sa_icb_cmd_len;
    logic [3:0]  sa_icb_cmd_wmask;
    logic        sa_icb_cmd_ready, sa_icb_w_ready, sa_icb_rsp_valid, sa_icb_rsp_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mma_timing_model #(
        .SIZE(16), .REG_WIDTH(32), .ADDR_WIDTH(32), .BUS_WIDTH(32), .LEN_WIDTH(3),
        .QDEPTH(4), .DIM_W(12), .CNT_W(24), .BASE_LAT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .calc_start(calc_start), .cfg_16bits_ia(cfg_16bits_ia),
        .sa_ready(sa_ready), .busy(busy), .lhs_base(lhs_base), .rhs_base(rhs_base),
        .dst_base(dst_base), .m(m), .n(n), .k(k), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .err_code(err_code), .sa_icb_cmd_valid(sa_icb_cmd_valid), .sa_icb_cmd_addr(sa_icb_cmd_addr),
        .sa_icb_cmd_read(sa_icb_cmd_read), .sa_icb_cmd_len(sa_icb_cmd_len),
        .sa_icb_cmd_wdata(sa_icb_cmd_wdata), .sa_icb_cmd_wmask(sa_icb_cmd_wmask),
        .sa_icb_w_valid(sa_icb_w_valid), .sa_icb_rsp_ready(sa_icb_rsp_ready),
        .sa_icb_cmd_ready(sa_icb_cmd_ready), .sa_icb_w_ready(sa_icb_w_ready),
        .sa_icb_rsp_valid(sa_icb_rsp_valid), .sa_icb_rsp_rdata(sa_icb_rsp_rdata),
        .sa_icb_rsp_err(sa_icb_rsp_err)
    );

    // Present one job's configuration with calc_start raised
    task automatic drive_job(input logic [31:0] mm, nn, kk, input logic cfg,
                             input logic [31:0] lb, rb, db);
        m = mm; n = nn; k = kk; cfg_16bits_ia = cfg;
        lhs_base = lb; rhs_base = rb; dst_base = db;
        calc_start = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; calc_start = 1'b0; wb_ready = 1'b0;
        sa_icb_cmd_ready = 1'b0; sa_icb_w_ready = 1'b0; sa_icb_rsp_valid = 1'b0;
        sa_icb_rsp_rdata = 32'h0; sa_icb_rsp_err = 1'b0;
        drive_job(32'd0, 32'd0, 32'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        calc_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({sa_ready, busy, wb_valid, err_code} !== 5'b10000) begin
            err_cnt++;
            $display("FAIL reset_status got %b expected 10000", {sa_ready, busy, wb_valid, err_code});
        end
        vec_cnt++;
        if ({sa_icb_cmd_valid, sa_icb_cmd_addr, sa_icb_cmd_read, sa_icb_cmd_len, sa_icb_cmd_wdata,
             sa_icb_cmd_wmask, sa_icb_w_valid, sa_icb_rsp_ready} !== {74'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL reset_icb got %h expected %h",
                     {sa_icb_cmd_valid, sa_icb_cmd_addr, sa_icb_cmd_read, sa_icb_cmd_len,
                      sa_icb_cmd_wdata, sa_icb_cmd_wmask, sa_icb_w_valid, sa_icb_rsp_ready},
                     {74'd0, 1'b1});
        end
        rst_n = 1'b1;
    endtask

    // Isolated job: wb_valid first seen after accept edge + L + 2, then a single pulse
    task automatic test_latency(input string name, input logic [31:0] mm, nn, kk, input logic cfg,
                                input logic [31:0] lb, rb, db, input int exp_l,
                                input logic [1:0] exp_err);
        int   edges;
        logic seen;
        logic [1:0] got_err;
        @(negedge clk);
        wb_ready = 1'b1;
        vec_cnt++;
        if (sa_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_ready got %b expected 1", name, sa_ready);
        end
        drive_job(mm, nn, kk, cfg, lb, rb, db);
        @(posedge clk);
        #1 calc_start = 1'b0;
        edges = 0; seen = 1'b0; got_err = 2'b00;
        while (!seen && edges < exp_l + 50) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                seen = 1'b1;
                got_err = err_code;
            end
        end
        vec_cnt++;
        if (!seen || edges != exp_l + 2) begin
            err_cnt++;
            $display("FAIL %s_latency got %0d (seen=%b) expected %0d", name, edges, seen, exp_l + 2);
        end
        vec_cnt++;
        if (got_err !== exp_err) begin
            err_cnt++;
            $display("FAIL %s_err got %b expected %b", name, got_err, exp_err);
        end
        @(negedge clk);
        vec_cnt++;
        if ({wb_valid, busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL %s_after_wb got wb_valid,busy=%b expected 00", name, {wb_valid, busy});
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] got[$];
        logic [1:0] exp_e[5];
        int n_wait;
        exp_e = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        @(negedge clk);
        wb_ready = 1'b0;
        drive_job(32'd1, 32'd1, 32'd1, 1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1 calc_start = 1'b0;
        n_wait = 0;
        @(negedge clk);
        while (wb_valid !== 1'b1 && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        vec_cnt++;
        if (wb_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_first_done got wb_valid=%b expected 1", wb_valid);
        end
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive_job(32'd1, 32'd1, 32'd0, 1'b0, 32'h0, 32'h0, 32'h0);
                1: drive_job(32'd1, 32'd1, 32'd1, 1'b0, 32'h2, 32'h0, 32'h0);
                2: drive_job(32'd2, 32'd1, 32'd1, 1'b0, 32'h0, 32'h0, 32'h0);
                3: drive_job(32'd0, 32'd1, 32'd1, 1'b0, 32'h0, 32'h0, 32'h0);
                default: drive_job(32'd1, 32'd1, 32'd1, 1'b0, 32'h0, 32'h1, 32'h0);
            endcase
            vec_cnt++;
            if (sa_ready !== (i < 4)) begin
                err_cnt++;
                $display("FAIL b2b_sa_ready[%0d] got %b expected %b", i, sa_ready, (i < 4));
            end
            @(posedge clk);
            @(negedge clk);
        end
        calc_start = 1'b0;
        repeat (4) begin
            vec_cnt++;
            if ({wb_valid, err_code, sa_ready, busy} !== 5'b10001) begin
                err_cnt++;
                $display("FAIL b2b_hold got wb,err,ready,busy=%b expected 10001",
                         {wb_valid, err_code, sa_ready, busy});
            end
`ifndef MMA_MODEL_ICB_PROBE_EN
            vec_cnt++;
            if ({sa_icb_cmd_valid, sa_icb_cmd_read} !== 2'b00) begin
                err_cnt++;
                $display("FAIL b2b_icb_idle got %b expected 00", {sa_icb_cmd_valid, sa_icb_cmd_read});
            end
`endif
            @(negedge clk);
        end
        wb_ready = 1'b1;
        repeat (100) begin
            if (wb_valid === 1'b1) got.push_back(err_code);
            @(negedge clk);
        end
        vec_cnt++;
        if (got.size() != 5) begin
            err_cnt++;
            $display("FAIL b2b_wb_count got %0d expected 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            vec_cnt++;
            if (got[i] !== exp_e[i]) begin
                err_cnt++;
                $display("FAIL b2b_order[%0d] got %b expected %b", i, got[i], exp_e[i]);
            end
        end
        vec_cnt++;
        if ({sa_ready, busy} !== 2'b10) begin
            err_cnt++;
            $display("FAIL b2b_drained got ready,busy=%b expected 10", {sa_ready, busy});
        end
    endtask

    task automatic test_reset_mid_job;
        logic fired;
        @(negedge clk);
        wb_ready = 1'b1;
        drive_job(32'd16, 32'd16, 32'd8, 1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1 drive_job(32'd1, 32'd1, 32'd1, 1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1 drive_job(32'd1, 32'd1, 32'd2, 1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1 calc_start = 1'b0;
        repeat (4) @(negedge clk);
        vec_cnt++;
        if ({busy, wb_valid} !== 2'b10) begin
            err_cnt++;
            $display("FAIL midrst_running got busy,wb=%b expected 10", {busy, wb_valid});
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({sa_ready, busy, wb_valid, err_code, sa_icb_cmd_valid, sa_icb_rsp_ready} !== 7'b1000001) begin
            err_cnt++;
            $display("FAIL midrst_outputs got %b expected 1000001",
                     {sa_ready, busy, wb_valid, err_code, sa_icb_cmd_valid, sa_icb_rsp_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        fired = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (wb_valid === 1'b1) fired = 1'b1;
        end
        vec_cnt++;
        if ({fired, busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL midrst_no_wb got fired,busy=%b expected 00", {fired, busy});
        end
    endtask

`ifdef MMA_MODEL_ICB_PROBE_EN
    task automatic test_probe(input logic rsp_e, input logic [1:0] exp_err);
        int n_wait;
        @(negedge clk);
        wb_ready = 1'b1;
        drive_job(32'd16, 32'd16, 32'd1, 1'b0, 32'h2000, 32'h0, 32'h0);
        @(posedge clk);
        #1 calc_start = 1'b0;
        n_wait = 0;
        while (sa_icb_cmd_valid !== 1'b1 && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        vec_cnt++;
        if ({sa_icb_cmd_valid, sa_icb_cmd_read, sa_icb_cmd_addr} !== {2'b11, 32'h2000}) begin
            err_cnt++;
            $display("FAIL probe_cmd got %h expected %h",
                     {sa_icb_cmd_valid, sa_icb_cmd_read, sa_icb_cmd_addr}, {2'b11, 32'h2000});
        end
        repeat (3) @(negedge clk);
        sa_icb_cmd_ready = 1'b1;
        @(posedge clk);
        #1 sa_icb_cmd_ready = 1'b0;
        @(negedge clk);
        sa_icb_rsp_valid = 1'b1; sa_icb_rsp_err = rsp_e;
        @(posedge clk);
        #1 sa_icb_rsp_valid = 1'b0; sa_icb_rsp_err = 1'b0;
        n_wait = 0;
        @(negedge clk);
        while (wb_valid !== 1'b1 && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        vec_cnt++;
        if ({wb_valid, err_code} !== {1'b1, exp_err}) begin
            err_cnt++;
            $display("FAIL probe_wb got %b expected %b", {wb_valid, err_code}, {1'b1, exp_err});
        end
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
`ifndef MMA_MODEL_ICB_PROBE_EN
        test_latency("base16",   32'd16, 32'd16, 32'd8, 1'b0, 32'h0,    32'h0,    32'h0, 12, 2'b00);
        test_latency("cfg16",    32'd33, 32'd16, 32'd8, 1'b1, 32'h0,    32'h0,    32'h0, 52, 2'b00);
        test_latency("partial",  32'd17, 32'd1,  32'd1, 1'b0, 32'h0,    32'h0,    32'h0,  6, 2'b00);
        test_latency("k_zero",   32'd16, 32'd16, 32'd0, 1'b0, 32'h0,    32'h0,    32'h0,  1, 2'b01);
        test_latency("lhs_mis",  32'd16, 32'd16, 32'd8, 1'b0, 32'h1002, 32'h0,    32'h0,  1, 2'b10);
        test_latency("both_err", 32'd0,  32'd16, 32'd8, 1'b0, 32'h1002, 32'h0,    32'h0,  1, 2'b01);
        test_latency("m_high",   32'h1010, 32'd1, 32'd1, 1'b0, 32'h0,   32'h0,    32'h0,  1, 2'b01);
        test_latency("dst_mis",  32'd1,  32'd1,  32'd1, 1'b0, 32'h0,    32'h0,    32'h3,  1, 2'b10);
`else
        test_probe(1'b1, 2'b11);
        test_probe(1'b0, 2'b00);
`endif
        test_back_to_back;
        test_reset_mid_job;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

endmodule
